adc_calc_scheduler: RTL and testbench
=====================================

ADC_CALC_SCHEDULER -- requirements
Module: adc_calc_scheduler

Interface
REQ-001 SHALL have parameters: CH_NUM, default 8, number of ADC channels sharing the FMA; MAX_OUT, default 16, maximum outstanding FMA operations and tag FIFO depth.
REQ-002 SHALL have ports (name direction width meaning):
- i_clk  in  1  single clock, all logic rising-edge
- i_rst  in  1  synchronous active-high reset
- i_en  in  1  scheduler enable
- i_s_tdata  in  CH_NUM*32  per-channel float32 ADC sample, channel k at bits [32k+31:32k]
- i_s_tvalid  in  CH_NUM  per-channel sample valid
- o_s_tready  out  CH_NUM  per-channel accept, one-hot or zero
- i_gain  in  CH_NUM*32  per-channel float32 gain
- i_offset  in  CH_NUM*32  per-channel float32 offset
- o_fma_a / o_fma_b / o_fma_c  out  32 each  sample / gain / offset to shared FMA (a*b+c)
- o_fma_tvalid  out  1  operand valid
- i_fma_tready  in  1  FMA accepts operands
- i_res_tdata  in  32  FMA result; in-order return
- i_res_tvalid  in  1  result valid, no backpressure
- o_res_tdata  out  CH_NUM*32  per-channel calibrated result register
- o_res_tvalid  out  CH_NUM  per-channel one-cycle update pulse
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky: result arrived with tag FIFO empty
REQ-003 SHALL use i_clk as the only clock and i_rst as synchronous active-high reset.

Function
REQ-004 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN when i_en=1; RUN->DRAIN when i_en=0; DRAIN->IDLE when outstanding=0 and o_fma_tvalid=0; DRAIN->RUN when i_en=1.
REQ-005 SHALL grant at most one channel per cycle, only in RUN, only when outstanding < MAX_OUT and (o_fma_tvalid=0 or i_fma_tready=1).
REQ-006 SHALL arbitrate round-robin: search starts at channel (last_grant+1) mod CH_NUM, wraps, lowest index after pointer wins; last_grant resets to CH_NUM-1 so channel 0 has first priority.
REQ-007 o_s_tready[k] SHALL be high combinationally in exactly the cycle channel k is granted; handshake completes when i_s_tvalid[k] and o_s_tready[k] are both high.
REQ-008 On grant in cycle N SHALL capture sample, i_gain[k], i_offset[k] into o_fma_a/b/c and assert o_fma_tvalid in cycle N+1; gain/offset changes after capture do not affect the issued operation.
REQ-009 o_fma_tvalid and operands SHALL hold stable until i_fma_tready=1; if no new grant that cycle, o_fma_tvalid drops next cycle.
REQ-010 SHALL push granted channel index into tag FIFO at grant; outstanding counter +1 on grant, -1 on i_res_tvalid, unchanged when both occur in the same cycle.
REQ-011 On i_res_tvalid with tag FIFO non-empty SHALL pop tag t, write i_res_tdata to o_res_tdata[t] and pulse o_res_tvalid[t] the next cycle (latency 1); other channels hold.
REQ-012 On i_res_tvalid with tag FIFO empty SHALL discard result, leave counter at 0, set o_err=1 until reset.
REQ-013 Push and pop in the same cycle at full FIFO SHALL be legal; grant logic SHALL never push when outstanding=MAX_OUT.
REQ-014 DRAIN SHALL issue no grants but SHALL keep presenting a pending o_fma_tvalid and collecting results.

Reset
REQ-015 On i_rst=1 SHALL clear: state=IDLE, outstanding=0, tag FIFO empty, last_grant=CH_NUM-1, o_fma_tvalid=0, o_fma_a/b/c=0, o_s_tready=0, o_res_tdata=0, o_res_tvalid=0, o_busy=0, o_err=0.
REQ-016 Reset mid-operation SHALL abandon in-flight tags; external FMA shares i_rst.

Verification
REQ-017 All 8 channels valid, i_fma_tready=1, i_en=1 -> grants 0,1,...,7,0 on consecutive cycles, o_fma_tvalid continuous.
REQ-018 Channel 3 sample 0x4B000000, gain 0x35A00000, offset 0xC1200000, model FMA latency 8 -> o_fma_a/b/c match at N+1, o_res_tvalid[3] pulses at issue+8+1, o_res_tdata[3]=model result.
REQ-019 i_fma_tready=0 for 5 cycles with channel 0 pending -> operands stable, no further grants, o_s_tready=0 until tready returns.
REQ-020 Stall results until outstanding=16 -> no grants; one result with simultaneous valid request -> one grant, outstanding remains 16.
REQ-021 i_en dropped with 4 outstanding -> DRAIN, no grants, o_busy=1 until 4th result, then IDLE; stray i_res_tvalid -> o_err=1.

Source files
------------

// File: rtl/adc_calc_scheduler.sv
// Purpose: shares one external FMA (a*b+c) between CH_NUM ADC channels with round-robin grants and in-order tag routing of results.
// Latency: operands appear one cycle after a grant; a returned result reaches its channel register one cycle after i_res_tvalid.
// Backpressure: operands hold while i_fma_tready is low; grants stop at MAX_OUT outstanding; results cannot be stalled.

module adc_tag_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // a push into a full FIFO is accepted when a pop frees a slot in the same cycle
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];
    assign empty   = (count == '0);

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is data-only, contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

module adc_calc_scheduler #(
    parameter int CH_NUM  = 8,
    parameter int MAX_OUT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [CH_NUM*32-1:0]   i_s_tdata,
    input  logic [CH_NUM-1:0]      i_s_tvalid,
    output logic [CH_NUM-1:0]      o_s_tready,
    input  logic [CH_NUM*32-1:0]   i_gain,
    input  logic [CH_NUM*32-1:0]   i_offset,
    output logic [31:0]            o_fma_a,
    output logic [31:0]            o_fma_b,
    output logic [31:0]            o_fma_c,
    output logic                   o_fma_tvalid,
    input  logic                   i_fma_tready,
    input  logic [31:0]            i_res_tdata,
    input  logic                   i_res_tvalid,
    output logic [CH_NUM*32-1:0]   o_res_tdata,
    output logic [CH_NUM-1:0]      o_res_tvalid,
    output logic                   o_busy,
    output logic                   o_err
);
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   last_grant;
    logic [OUT_W-1:0]  outstanding;
    logic              issue_ok;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_idx;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [31:0]       sel_c;
    logic              res_pop;
    logic              tag_empty;
    logic [CH_W-1:0]   tag_dout;

    // a new operation may be granted only when the operand slot is free or being consumed
    assign issue_ok = (state == RUN) &&
                      (outstanding < OUT_W'(MAX_OUT)) &&
                      (!o_fma_tvalid || i_fma_tready);
    assign res_pop  = i_res_tvalid && !tag_empty;
    assign o_busy   = (state != IDLE);

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: DRAIN waits for every in-flight result and the pending operand to retire
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = RUN;
            RUN:     if (!i_en) state_nxt = DRAIN;
            DRAIN: begin
                if (i_en) begin
                    state_nxt = RUN;
                end else if ((outstanding == '0) && !o_fma_tvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // round-robin search starting one past the last granted channel
    always_comb begin
        logic [CH_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = CH_W'((int'(last_grant) + 1 + i) % CH_NUM);
            if (issue_ok && !grant_vld && i_s_tvalid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // one-hot ready for the granted channel and operand selection
    always_comb begin
        o_s_tready = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_c      = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (grant_vld && (grant_idx == CH_W'(k))) begin
                o_s_tready[k] = 1'b1;
                sel_a         = i_s_tdata[k*32 +: 32];
                sel_b         = i_gain[k*32 +: 32];
                sel_c         = i_offset[k*32 +: 32];
            end
        end
    end

    // arbitration pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant <= CH_W'(CH_NUM - 1);
        end else if (grant_vld) begin
            last_grant <= grant_idx;
        end
    end

    // operand register: gain/offset are snapshotted at grant so later changes do not leak in
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fma_tvalid <= 1'b0;
            o_fma_a      <= '0;
            o_fma_b      <= '0;
            o_fma_c      <= '0;
        end else if (grant_vld) begin
            o_fma_tvalid <= 1'b1;
            o_fma_a      <= sel_a;
            o_fma_b      <= sel_b;
            o_fma_c      <= sel_c;
        end else if (i_fma_tready) begin
            o_fma_tvalid <= 1'b0;
        end
    end

    // outstanding count tracks granted-but-unreturned operations; stray results do not decrement
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding <= '0;
        end else begin
            case ({grant_vld, res_pop})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    adc_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (grant_vld),
        .din   (grant_idx),
        .pop   (res_pop),
        .dout  (tag_dout),
        .empty (tag_empty)
    );

    // route each returned result to the channel named by the oldest tag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_tdata  <= '0;
            o_res_tvalid <= '0;
            o_err        <= 1'b0;
        end else begin
            o_res_tvalid <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                if (res_pop && (tag_dout == CH_W'(k))) begin
                    o_res_tdata[k*32 +: 32] <= i_res_tdata;
                    o_res_tvalid[k]         <= 1'b1;
                end
            end
            if (i_res_tvalid && tag_empty) begin
                o_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_calc_scheduler.sv
// Purpose: directed self-checking bench for adc_calc_scheduler with hand-computed expectations.
// Latency: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
// Backpressure: FMA ready and result returns are driven explicitly by each scenario.

module tb_adc_calc_scheduler;
    localparam int CH_NUM  = 8;
    localparam int MAX_OUT = 16;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_en;
    logic [CH_NUM*32-1:0]  i_s_tdata;
    logic [CH_NUM-1:0]     i_s_tvalid;
    logic [CH_NUM-1:0]     o_s_tready;
    logic [CH_NUM*32-1:0]  i_gain;
    logic [CH_NUM*32-1:0]  i_offset;
    logic [31:0]           o_fma_a;
    logic [31:0]           o_fma_b;
    logic [31:0]           o_fma_c;
    logic                  o_fma_tvalid;
    logic                  i_fma_tready;
    logic [31:0]           i_res_tdata;
    logic                  i_res_tvalid;
    logic [CH_NUM*32-1:0]  o_res_tdata;
    logic [CH_NUM-1:0]     o_res_tvalid;
    logic                  o_busy;
    logic                  o_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] smp [CH_NUM];
    logic [31:0] gn  [CH_NUM];
    logic [31:0] ofs [CH_NUM];

    always #5 i_clk = ~i_clk;

    adc_calc_scheduler #(
        .CH_NUM  (CH_NUM),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_s_tdata    (i_s_tdata),
        .i_s_tvalid   (i_s_tvalid),
        .o_s_tready   (o_s_tready),
        .i_gain       (i_gain),
        .i_offset     (i_offset),
        .o_fma_a      (o_fma_a),
        .o_fma_b      (o_fma_b),
        .o_fma_c      (o_fma_c),
        .o_fma_tvalid (o_fma_tvalid),
        .i_fma_tready (i_fma_tready),
        .i_res_tdata  (i_res_tdata),
        .i_res_tvalid (i_res_tvalid),
        .o_res_tdata  (o_res_tdata),
        .o_res_tvalid (o_res_tvalid),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    task automatic pack_inputs();
        for (int k = 0; k < CH_NUM; k++) begin
            i_s_tdata[k*32 +: 32] = smp[k];
            i_gain[k*32 +: 32]    = gn[k];
            i_offset[k*32 +: 32]  = ofs[k];
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_en         = 1'b0;
        i_s_tvalid   = '0;
        i_fma_tready = 1'b0;
        i_res_tvalid = 1'b0;
        i_res_tdata  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            smp[k] = 32'h1000_0000 + 32'(k);
            gn[k]  = 32'h2000_0000 + 32'(k);
            ofs[k] = 32'h3000_0000 + 32'(k);
        end
        pack_inputs();
        next_cycle();
        next_cycle();
        i_rst = 1'b0;
    endtask

    // reset in the middle of a stalled operation must clear everything
    task automatic test_reset();
        do_reset();
        i_en         = 1'b1;
        i_s_tvalid   = '1;
        i_fma_tready = 1'b0;
        for (int n = 0; n < 4; n++) next_cycle();
        do_reset();
        i_s_tvalid = '1;
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL reset_tready: got %h expected 00", o_s_tready); end
        checks++; if (o_fma_tvalid !== 1'b0) begin errors++; $display("FAIL reset_fma_tvalid: got %b expected 0", o_fma_tvalid); end
        checks++; if ({o_fma_a, o_fma_b, o_fma_c} !== 96'd0) begin errors++; $display("FAIL reset_operands: got %h %h %h expected 0", o_fma_a, o_fma_b, o_fma_c); end
        checks++; if (o_res_tvalid !== 8'h00) begin errors++; $display("FAIL reset_res_tvalid: got %h expected 00", o_res_tvalid); end
        checks++; if (o_res_tdata !== 256'd0) begin errors++; $display("FAIL reset_res_tdata: got %h expected 0", o_res_tdata); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
        next_cycle();
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL idle_no_grant: got %h expected 00", o_s_tready); end
        next_cycle();
    endtask

    // all channels requesting, FMA always ready
    task automatic test_round_robin();
        logic [CH_NUM-1:0] exp_rdy;
        do_reset();
        i_en         = 1'b1;
        i_s_tvalid   = '1;
        i_fma_tready = 1'b1;
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL rr_idle_cycle: got %h expected 00", o_s_tready); end
        next_cycle();
        for (int n = 0; n < 9; n++) begin
            exp_rdy = '0;
            exp_rdy[n % CH_NUM] = 1'b1;
            @(negedge i_clk);
            checks++; if (o_s_tready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %h expected %h", n, o_s_tready, exp_rdy); end
            if (n > 0) begin
                checks++; if (o_fma_tvalid !== 1'b1) begin errors++; $display("FAIL rr_tvalid[%0d]: got %b expected 1", n, o_fma_tvalid); end
                checks++; if (o_fma_a !== smp[(n-1) % CH_NUM]) begin errors++; $display("FAIL rr_fma_a[%0d]: got %h expected %h", n, o_fma_a, smp[(n-1) % CH_NUM]); end
            end
            next_cycle();
        end
    endtask

    // single channel 3 operation, result returned 8 cycles after issue
    task automatic test_calc_latency();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [31:0] vc [2];
        logic [31:0] vr [2];
        // 2^23 * 1.25*2^-20 + (-10.0) = 0.0
        va[0] = 32'h4B00_0000; vb[0] = 32'h35A0_0000; vc[0] = 32'hC120_0000; vr[0] = 32'h0000_0000;
        // 3.0 * 2.0 + 1.0 = 7.0
        va[1] = 32'h4040_0000; vb[1] = 32'h4000_0000; vc[1] = 32'h3F80_0000; vr[1] = 32'h40E0_0000;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            smp[3] = va[v]; gn[3] = vb[v]; ofs[3] = vc[v];
            pack_inputs();
            i_en         = 1'b1;
            i_fma_tready = 1'b1;
            next_cycle();
            i_s_tvalid = 8'h08;
            @(negedge i_clk);
            checks++; if (o_s_tready !== 8'h08) begin errors++; $display("FAIL calc_grant[%0d]: got %h expected 08", v, o_s_tready); end
            next_cycle();
            i_s_tvalid = '0;
            gn[3]  = 32'hFFFF_FFFF;
            ofs[3] = 32'h1234_5678;
            pack_inputs();
            @(negedge i_clk);
            checks++; if (o_fma_tvalid !== 1'b1) begin errors++; $display("FAIL calc_tvalid[%0d]: got %b expected 1", v, o_fma_tvalid); end
            checks++; if ({o_fma_a, o_fma_b, o_fma_c} !== {va[v], vb[v], vc[v]}) begin errors++; $display("FAIL calc_operands[%0d]: got %h %h %h expected %h %h %h", v, o_fma_a, o_fma_b, o_fma_c, va[v], vb[v], vc[v]); end
            next_cycle();
            for (int d = 1; d <= 8; d++) begin
                if (d == 8) begin
                    i_res_tvalid = 1'b1;
                    i_res_tdata  = vr[v];
                end
                @(negedge i_clk);
                checks++; if (o_res_tvalid !== 8'h00) begin errors++; $display("FAIL calc_early_pulse[%0d/%0d]: got %h expected 00", v, d, o_res_tvalid); end
                next_cycle();
            end
            i_res_tvalid = 1'b0;
            @(negedge i_clk);
            checks++; if (o_res_tvalid !== 8'h08) begin errors++; $display("FAIL calc_pulse[%0d]: got %h expected 08", v, o_res_tvalid); end
            checks++; if (o_res_tdata[96 +: 32] !== vr[v]) begin errors++; $display("FAIL calc_result[%0d]: got %h expected %h", v, o_res_tdata[96 +: 32], vr[v]); end
            checks++; if ({o_res_tdata[255:128], o_res_tdata[95:0]} !== 224'd0) begin errors++; $display("FAIL calc_other_ch[%0d]: got %h expected 0", v, o_res_tdata); end
            next_cycle();
            @(negedge i_clk);
            checks++; if (o_res_tvalid !== 8'h00) begin errors++; $display("FAIL calc_pulse_end[%0d]: got %h expected 00", v, o_res_tvalid); end
            next_cycle();
        end
    endtask

    // FMA stalls for 5 cycles with channel 0 pending
    task automatic test_backpressure();
        do_reset();
        i_en         = 1'b1;
        i_s_tvalid   = 8'h03;
        i_fma_tready = 1'b0;
        next_cycle();
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h01) begin errors++; $display("FAIL bp_first_grant: got %h expected 01", o_s_tready); end
        next_cycle();
        for (int n = 0; n < 5; n++) begin
            @(negedge i_clk);
            checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL bp_no_grant[%0d]: got %h expected 00", n, o_s_tready); end
            checks++; if (o_fma_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid[%0d]: got %b expected 1", n, o_fma_tvalid); end
            checks++; if ({o_fma_a, o_fma_b, o_fma_c} !== {smp[0], gn[0], ofs[0]}) begin errors++; $display("FAIL bp_operands[%0d]: got %h %h %h expected %h %h %h", n, o_fma_a, o_fma_b, o_fma_c, smp[0], gn[0], ofs[0]); end
            next_cycle();
        end
        i_fma_tready = 1'b1;
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h02) begin errors++; $display("FAIL bp_resume_grant: got %h expected 02", o_s_tready); end
        next_cycle();
        i_s_tvalid = '0;
        @(negedge i_clk);
        checks++; if (o_fma_tvalid !== 1'b1 || o_fma_a !== smp[1]) begin errors++; $display("FAIL bp_second_op: got %b %h expected 1 %h", o_fma_tvalid, o_fma_a, smp[1]); end
        next_cycle();
        @(negedge i_clk);
        checks++; if (o_fma_tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_drop: got %b expected 0", o_fma_tvalid); end
        next_cycle();
    endtask

    // fill to MAX_OUT outstanding, then release exactly one result
    task automatic test_max_outstanding();
        logic [CH_NUM-1:0] exp_rdy;
        do_reset();
        i_en         = 1'b1;
        i_s_tvalid   = '1;
        i_fma_tready = 1'b1;
        next_cycle();
        for (int n = 0; n < MAX_OUT; n++) begin
            exp_rdy = '0;
            exp_rdy[n % CH_NUM] = 1'b1;
            @(negedge i_clk);
            checks++; if (o_s_tready !== exp_rdy) begin errors++; $display("FAIL max_fill[%0d]: got %h expected %h", n, o_s_tready, exp_rdy); end
            next_cycle();
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge i_clk);
            checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL max_full_hold[%0d]: got %h expected 00", n, o_s_tready); end
            next_cycle();
        end
        i_res_tvalid = 1'b1;
        i_res_tdata  = 32'hCAFE_0001;
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL max_same_cycle: got %h expected 00", o_s_tready); end
        next_cycle();
        i_res_tvalid = 1'b0;
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h01) begin errors++; $display("FAIL max_one_grant: got %h expected 01", o_s_tready); end
        checks++; if (o_res_tvalid !== 8'h01 || o_res_tdata[31:0] !== 32'hCAFE_0001) begin errors++; $display("FAIL max_result: got %h %h expected 01 cafe0001", o_res_tvalid, o_res_tdata[31:0]); end
        next_cycle();
        for (int n = 0; n < 2; n++) begin
            @(negedge i_clk);
            checks++; if (o_s_tready !== 8'h00) begin errors++; $display("FAIL max_refull[%0d]: got %h expected 00", n, o_s_tready); end
            next_cycle();
        end
    endtask

    // drop enable with 4 in flight, drain them, then a stray result
    task automatic test_drain();
        logic [CH_NUM-1:0] exp_rdy;
        do_reset();
        i_en         = 1'b1;
        i_s_tvalid   = 8'h0F;
        i_fma_tready = 1'b1;
        next_cycle();
        for (int n = 0; n < 4; n++) begin
            exp_rdy = '0;
            exp_rdy[n] = 1'b1;
            @(negedge i_clk);
            checks++; if (o_s_tready !== exp_rdy) begin errors++; $display("FAIL drain_fill[%0d]: got %h expected %h", n, o_s_tready, exp_rdy); end
            next_cycle();
        end
        i_s_tvalid = '0;
        i_en       = 1'b0;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL drain_busy_run: got %b expected 1", o_busy); end
        next_cycle();
        i_s_tvalid = 8'h0F;
        @(negedge i_clk);
        checks++; if (o_s_tready !== 8'h00 || o_busy !== 1'b1) begin errors++; $display("FAIL drain_no_grant: got %h %b expected 00 1", o_s_tready, o_busy); end
        next_cycle();
        for (int n = 0; n < 4; n++) begin
            i_res_tvalid = 1'b1;
            i_res_tdata  = 32'hD000_0000 + 32'(n);
            @(negedge i_clk);
            checks++; if (o_s_tready !== 8'h00 || o_busy !== 1'b1) begin errors++; $display("FAIL drain_collect[%0d]: got %h %b expected 00 1", n, o_s_tready, o_busy); end
            if (n > 0) begin
                exp_rdy = '0;
                exp_rdy[n-1] = 1'b1;
                checks++; if (o_res_tvalid !== exp_rdy) begin errors++; $display("FAIL drain_pulse[%0d]: got %h expected %h", n, o_res_tvalid, exp_rdy); end
            end
            next_cycle();
        end
        i_res_tvalid = 1'b0;
        @(negedge i_clk);
        checks++; if (o_res_tvalid !== 8'h08 || o_res_tdata[96 +: 32] !== 32'hD000_0003) begin errors++; $display("FAIL drain_last: got %h %h expected 08 d0000003", o_res_tvalid, o_res_tdata[96 +: 32]); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL drain_busy_last: got %b expected 1", o_busy); end
        next_cycle();
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0 || o_s_tready !== 8'h00) begin errors++; $display("FAIL drain_idle: got %b %h expected 0 00", o_busy, o_s_tready); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL drain_err_clean: got %b expected 0", o_err); end
        next_cycle();
        i_res_tvalid = 1'b1;
        i_res_tdata  = 32'hBAD0_BAD0;
        next_cycle();
        i_res_tvalid = 1'b0;
        @(negedge i_clk);
        checks++; if (o_err !== 1'b1 || o_res_tvalid !== 8'h00) begin errors++; $display("FAIL stray_err: got %b %h expected 1 00", o_err, o_res_tvalid); end
        next_cycle();
        next_cycle();
        @(negedge i_clk);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b expected 1", o_err); end
        checks++; if (o_res_tdata[31:0] !== 32'hD000_0000) begin errors++; $display("FAIL stray_no_write: got %h expected d0000000", o_res_tdata[31:0]); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_calc_latency();
        test_backpressure();
        test_max_outstanding();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
